arith_accum: RTL and testbench

ARITH_ACCUM -- requirements
Module: arith_accum

---
 rtl/arith_pkg.sv | 20 ++
 rtl/arith_nbit.sv | 15 +
 rtl/arith_accum.sv | 92 +++++++++
 tb/tb_arith_accum.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/arith_pkg.sv
// Shared types and helpers for the arith_* blocks: accumulator state encoding
// and a constant-foldable ceil(log2) used to size counters and sums.
package arith_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/arith_nbit.sv
// Plain N-bit ripple-style adder with carry in/out; synthesis maps the '+'
// onto whatever adder structure suits the target.
module arith_nbit #(
  parameter int N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         carry_in,
  output logic [N-1:0] sum,
  output logic         carry_out
);

  assign {carry_out, sum} = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, carry_in};

endmodule

// File: rtl/arith_accum.sv
// Accumulates K operands {carry_in, sum_in} from an upstream adder and hands
// the total downstream over a valid/ready pair.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1; the source holds its data while valid=1 and ready=0, and ready is
// driven from registered state only, never combinationally from valid.
module arith_accum
  import arith_pkg::*;
#(
  parameter  int N     = 4,
  parameter  int K     = 4,
  localparam int CNT_W = clog2(K),
  localparam int ACC_W = N + 1 + CNT_W
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic [N-1:0]     sum_in,
  input  logic             carry_in,
  input  logic             valid_in,
  output logic             ready_out,
  input  logic             clear_in,
  output logic [ACC_W-1:0] acc_out,
  output logic             valid_out,
  input  logic             ready_in,
  output state_t           state_dbg
);

  state_t             state;
  state_t             next_state;
  logic [ACC_W-1:0]   acc;
  logic [ACC_W-1:0]   acc_sum;
  logic [ACC_W-1:0]   operand;
  logic [CNT_W-1:0]   cnt;
  logic               accept;
  logic               last_sample;
  logic               release_result;
  logic               unused_carry;

  assign operand        = {{CNT_W{1'b0}}, carry_in, sum_in};
  assign ready_out      = (state != DONE);
  assign valid_out      = (state == DONE);
  assign accept         = valid_in && ready_out;
  assign last_sample    = (cnt == CNT_W'(K - 1));
  assign release_result = (state == DONE) && ready_in;
  assign acc_out        = (state == DONE) ? acc : '0;
  assign state_dbg      = state;

  // The total cannot exceed K*(2^(N+1)-1), so the adder's carry never sets.
  arith_nbit #(
    .N(ACC_W)
  ) u_add (
    .a        (acc),
    .b        (operand),
    .carry_in (1'b0),
    .sum      (acc_sum),
    .carry_out(unused_carry)
  );

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (accept) next_state = ACCUM;
      ACCUM:   if (accept && last_sample) next_state = DONE;
      DONE:    if (ready_in) next_state = IDLE;
      default: next_state = IDLE;
    endcase
    // Clear overrides both an accept and a downstream release.
    if (clear_in) next_state = IDLE;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      acc <= '0;
      cnt <= '0;
    end else if (clear_in || release_result) begin
      acc <= '0;
      cnt <= '0;
    end else if (accept) begin
      acc <= acc_sum;
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_arith_accum.sv
// Bench for arith_accum (N=4, K=4): queue-based reference model checked every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_arith_accum;
  import arith_pkg::*;

  localparam int N     = 4;
  localparam int K     = 4;
  localparam int ACC_W = N + 1 + clog2(K);

  logic             clk;
  logic             rst_n;
  logic [N-1:0]     sum_in;
  logic             carry_in;
  logic             valid_in;
  logic             ready_out;
  logic             clear_in;
  logic [ACC_W-1:0] acc_out;
  logic             valid_out;
  logic             ready_in;
  state_t           state_dbg;

  int checks = 0;
  int errors = 0;
  int results = 0;

  logic [N:0]       pend_q[$];
  logic [ACC_W-1:0] exp_q[$];

  arith_accum #(.N(N), .K(K)) dut (
    .clk_in   (clk),
    .rst_n_in (rst_n),
    .sum_in   (sum_in),
    .carry_in (carry_in),
    .valid_in (valid_in),
    .ready_out(ready_out),
    .clear_in (clear_in),
    .acc_out  (acc_out),
    .valid_out(valid_out),
    .ready_in (ready_in),
    .state_dbg(state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int pend_total();
    int t;
    t = 0;
    foreach (pend_q[i]) t += int'(pend_q[i]);
    return t;
  endfunction

  // Reference model: collect K accepted operands, then hold their sum until
  // the downstream takes it. Ready is simply "no result is being held".
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q.delete();
      exp_q.delete();
    end else if (clear_in) begin
      pend_q.delete();
      exp_q.delete();
    end else if (exp_q.size() != 0) begin
      if (ready_in) void'(exp_q.pop_front());
    end else if (valid_in) begin
      pend_q.push_back({carry_in, sum_in});
      if (pend_q.size() == K) begin
        exp_q.push_back(ACC_W'(pend_total()));
        pend_q.delete();
        results <= results + 1;
      end
    end
  end

  // compare process
  always @(negedge clk) begin
    check("valid_out", int'(valid_out), int'(exp_q.size() != 0));
    check("ready_out", int'(ready_out), int'(exp_q.size() == 0));
    check("acc_out", int'(acc_out), (exp_q.size() != 0) ? int'(exp_q[0]) : 0);
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic c, input logic [N-1:0] s);
    valid_in = 1'b1;
    carry_in = c;
    sum_in   = s;
    step();
  endtask

  task automatic idle();
    valid_in = 1'b0;
    carry_in = 1'b0;
    sum_in   = '0;
  endtask

  task automatic release_result();
    ready_in = 1'b1;
    step();
    ready_in = 1'b0;
  endtask

  initial begin
    int steps;
    int idx;
    bit got;

    rst_n    = 1'b0;
    sum_in   = '0;
    carry_in = 1'b0;
    valid_in = 1'b0;
    clear_in = 1'b0;
    ready_in = 1'b0;
    #2;
    check("rst_valid", int'(valid_out), 0);
    check("rst_ready", int'(ready_out), 1);
    check("rst_acc", int'(acc_out), 0);
    check("rst_state", int'(state_dbg), 0);
    #10 rst_n = 1'b1;
    step();

    // four back-to-back operands, result one edge after the 4th accept
    send(1'b0, 4'd5);
    send(1'b1, 4'd3);
    send(1'b1, 4'd15);
    check("r032_not_yet", int'(valid_out), 0);
    send(1'b0, 4'd0);
    idle();
    check("r032_valid", int'(valid_out), 1);
    check("r032_acc", int'(acc_out), 55);

    // result held while downstream stalls
    for (int i = 0; i < 3; i++) begin
      step();
      check("r034_hold_acc", int'(acc_out), 55);
      check("r034_hold_ready", int'(ready_out), 0);
    end
    release_result();
    check("r034_released_valid", int'(valid_out), 0);
    check("r034_released_acc", int'(acc_out), 0);
    check("r034_released_ready", int'(ready_out), 1);

    // maximum operands, no wrap
    for (int i = 0; i < 4; i++) send(1'b1, 4'd15);
    idle();
    check("r033_acc", int'(acc_out), 124);
    check("r033_ready", int'(ready_out), 0);
    release_result();

    // clear drops the partial sum and the same-cycle sample
    send(1'b0, 4'd5);
    send(1'b0, 4'd3);
    clear_in = 1'b1;
    send(1'b0, 4'd7);
    clear_in = 1'b0;
    for (int i = 0; i < 4; i++) send(1'b0, 4'd5);
    idle();
    check("r035_acc", int'(acc_out), 20);
    release_result();

    // asynchronous reset in the middle of a sum
    send(1'b0, 4'd1);
    send(1'b0, 4'd2);
    idle();
    #3 rst_n = 1'b0;
    #1;
    check("r036_async_valid", int'(valid_out), 0);
    check("r036_async_ready", int'(ready_out), 1);
    check("r036_async_state", int'(state_dbg), 0);
    step();
    #3 rst_n = 1'b1;
    send(1'b0, 4'd1);
    send(1'b0, 4'd2);
    send(1'b0, 4'd3);
    send(1'b0, 4'd4);
    idle();
    check("r036_acc", int'(acc_out), 10);
    release_result();

    // valid toggling every cycle stalls without corrupting the sum
    steps = 0;
    idx   = 0;
    got   = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      if ((i % 2) == 0 && idx < 4) begin
        valid_in = 1'b1;
        sum_in   = N'(idx + 1);
        idx++;
      end else begin
        valid_in = 1'b0;
      end
      step();
      steps++;
      if (valid_out) got = 1'b1;
    end
    idle();
    check("r037_latency", steps, 7);
    check("r037_acc", int'(acc_out), 10);
    release_result();

    // random traffic, one asynchronous reset in the middle
    for (int i = 0; i < 1500; i++) begin
      valid_in = ($urandom_range(0, 3) != 0);
      carry_in = 1'($urandom_range(0, 1));
      sum_in   = ($urandom_range(0, 3) == 0) ? 4'd15 : N'($urandom_range(0, 15));
      ready_in = ($urandom_range(0, 2) == 0);
      clear_in = ($urandom_range(0, 39) == 0);
      if (i == 700) begin
        #2 rst_n = 1'b0;
        #1;
        check("rand_async_valid", int'(valid_out), 0);
        check("rand_async_acc", int'(acc_out), 0);
        #1 rst_n = 1'b1;
      end
      step();
    end
    idle();
    clear_in = 1'b0;
    ready_in = 1'b0;
    step();
    check("rand_results_seen", int'(results > 50), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
